// File: rtl/imem_fetch_buffer.sv
// ============================================================================
// Module   : imem_fetch_buffer
// Purpose  : Gathers the 10 bytes of a Y86 instruction at a PC from 64-bit
//            little-endian instruction memory via a req/ack handshake.
//            Optional: IMEM_WORD_REUSE_EN reuses the last word read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_buffer #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [63:0] pc_i,
    input  logic        req_i,
    output logic        busy_o,
    output logic [79:0] instr_o,
    output logic        instr_valid_o,
    output logic        mem_error_o,
    output logic        mem_req_o,
    output logic [63:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [63:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [63:0] c_PC_MAX = 64'(IMEM_BYTES - 10);

    state_t      r_state;
    logic [2:0]  r_pc_off;
    logic        r_three;
    logic [63:0] r_w0;
    logic [63:0] r_w1;

    logic [63:0]  w_base;
    logic         w_last;
    logic [191:0] w_cat;
    logic [191:0] w_shifted;

`ifdef IMEM_WORD_REUSE_EN
    logic [60:0] r_tag;
    logic        r_tag_valid;
    logic [63:0] r_last_word;
    logic        w_hit;
    assign w_hit = r_tag_valid && (r_tag == pc_i[63:3]);
`endif

    assign w_base = {pc_i[63:3], 3'b000};
    assign w_last = ((r_state == S_RD1) && !r_three) || (r_state == S_RD2);

    // The final word is taken straight from the bus so instr_o is ready on entry to DONE.
    always_comb begin
        w_cat = {64'd0, r_w1, r_w0};
        if (r_state == S_RD1) begin
            w_cat[127:64] = mem_rdata_i;
        end
        if (r_state == S_RD2) begin
            w_cat[191:128] = mem_rdata_i;
        end
    end

    assign w_shifted = w_cat >> {r_pc_off, 3'b000};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= S_IDLE;
            r_pc_off      <= 3'd0;
            r_three       <= 1'b0;
            r_w0          <= 64'd0;
            r_w1          <= 64'd0;
            busy_o        <= 1'b0;
            instr_o       <= 80'd0;
            instr_valid_o <= 1'b0;
            mem_error_o   <= 1'b0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= 64'd0;
`ifdef IMEM_WORD_REUSE_EN
            r_tag         <= 61'd0;
            r_tag_valid   <= 1'b0;
            r_last_word   <= 64'd0;
`endif
        end else begin
            instr_valid_o <= 1'b0;
            mem_error_o   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        busy_o   <= 1'b1;
                        r_pc_off <= pc_i[2:0];
                        r_three  <= &pc_i[2:0];
                        if (pc_i > c_PC_MAX) begin
                            r_state       <= S_ERR;
                            instr_valid_o <= 1'b1;
                            mem_error_o   <= 1'b1;
                            instr_o       <= 80'd0;
                        end else begin
                            mem_req_o <= 1'b1;
`ifdef IMEM_WORD_REUSE_EN
                            if (w_hit) begin
                                r_w0       <= r_last_word;
                                mem_addr_o <= w_base + 64'd8;
                                r_state    <= S_RD1;
                            end else begin
                                mem_addr_o <= w_base;
                                r_state    <= S_RD0;
                            end
`else
                            mem_addr_o <= w_base;
                            r_state    <= S_RD0;
`endif
                        end
                    end
                end
                S_RD0: begin
                    if (mem_ack_i) begin
                        r_w0       <= mem_rdata_i;
                        mem_addr_o <= mem_addr_o + 64'd8;
                        r_state    <= S_RD1;
                    end
                end
                S_RD1, S_RD2: begin
                    if (mem_ack_i) begin
                        if (r_state == S_RD1) begin
                            r_w1 <= mem_rdata_i;
                        end
                        if (w_last) begin
                            mem_req_o     <= 1'b0;
                            instr_valid_o <= 1'b1;
                            instr_o       <= w_shifted[79:0];
                            r_state       <= S_DONE;
`ifdef IMEM_WORD_REUSE_EN
                            r_tag         <= mem_addr_o[63:3];
                            r_tag_valid   <= 1'b1;
                            r_last_word   <= mem_rdata_i;
`endif
                        end else begin
                            mem_addr_o <= mem_addr_o + 64'd8;
                            r_state    <= S_RD2;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy_o    <= 1'b0;
                    mem_req_o <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_buffer.sv
// ============================================================================
// Module   : tb_imem_fetch_buffer
// Purpose  : Directed self-checking bench for imem_fetch_buffer against a
//            memory whose byte n holds n[7:0].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic [63:0] pc_i;
    logic        req_i;
    logic        busy_o;
    logic [79:0] instr_o;
    logic        instr_valid_o;
    logic        mem_error_o;
    logic        mem_req_o;
    logic [63:0] mem_addr_o;
    logic        mem_ack_i;
    logic [63:0] mem_rdata_i;

    int          total = 0;
    int          bad = 0;
    int          ack_delay = 0;
    int          wcnt = 0;
    int          req_cycles = 0;
    logic        force_ack = 1'b0;
    logic [63:0] addr_q[$];

    imem_fetch_buffer #(.IMEM_BYTES(1024)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .pc_i          (pc_i),
        .req_i         (req_i),
        .busy_o        (busy_o),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .mem_error_o   (mem_error_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Memory model: byte n = n[7:0], ack after ack_delay wait cycles.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            mem_rdata_i[8*k +: 8] = 8'(mem_addr_o + 64'(k));
        end
    end
    assign mem_ack_i = force_ack || (mem_req_o && (wcnt >= ack_delay));

    always @(posedge clk) begin
        if (!mem_req_o || mem_ack_i) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (mem_req_o) req_cycles <= req_cycles + 1;
        if (mem_req_o && mem_ack_i) addr_q.push_back(mem_addr_o);
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_addrs(input string tag, input int n,
                             input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] a2);
        logic [63:0] exp_a[3];
        exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2;
        chk({tag, "_nreads"}, 80'(addr_q.size()), 80'(n));
        for (int i = 0; i < n; i++) begin
            if (i < addr_q.size()) chk({tag, "_addr"}, 80'(addr_q[i]), 80'(exp_a[i]));
        end
    endtask

    task automatic fetch(input string tag, input logic [63:0] pc, input int exp_lat,
                         input logic [79:0] exp_instr, input logic exp_err);
        int c;
        addr_q.delete();
        @(negedge clk);
        pc_i  = pc;
        req_i = 1'b1;
        @(posedge clk);
        #1 req_i = 1'b0;
        c = 1;
        @(negedge clk);
        while (!instr_valid_o && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_latency"}, 80'(c), 80'(exp_lat));
        chk({tag, "_instr"}, instr_o, exp_instr);
        chk({tag, "_err"}, 80'(mem_error_o), 80'(exp_err));
        @(negedge clk);
        chk({tag, "_strobe1cyc"}, 80'(instr_valid_o), 80'd0);
        chk({tag, "_hold"}, instr_o, exp_instr);
    endtask

    initial begin
        int rc;
        rst_n_i = 1'b0;
        pc_i    = 64'd0;
        req_i   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 80'(busy_o), 80'd0);
        chk("rst_valid", 80'(instr_valid_o), 80'd0);
        chk("rst_req", 80'(mem_req_o), 80'd0);
        chk("rst_addr", 80'(mem_addr_o), 80'd0);
        chk("rst_instr", instr_o, 80'd0);
        rst_n_i = 1'b1;

        fetch("pc0", 64'd0, 3, 80'h09080706050403020100, 1'b0);
        chk_addrs("pc0", 2, 64'd0, 64'd8, 64'd0);

        fetch("pc7", 64'd7, 4, 80'h100F0E0D0C0B0A090807, 1'b0);
        chk_addrs("pc7", 3, 64'd0, 64'd8, 64'd16);

        fetch("pc1014", 64'd1014, 3, 80'hFFFEFDFCFBFAF9F8F7F6, 1'b0);
        chk_addrs("pc1014", 2, 64'd1008, 64'd1016, 64'd0);

        rc = req_cycles;
        fetch("pc1015", 64'd1015, 1, 80'd0, 1'b1);
        chk("pc1015_noreq", 80'(req_cycles - rc), 80'd0);
        chk_addrs("pc1015", 0, 64'd0, 64'd0, 64'd0);

        rc = req_cycles;
        fetch("pcmax", 64'hFFFF_FFFF_FFFF_FFFC, 1, 80'd0, 1'b1);
        chk("pcmax_noreq", 80'(req_cycles - rc), 80'd0);

        // Three wait cycles per word, with a stray request mid-fetch.
        ack_delay = 3;
        addr_q.delete();
        @(negedge clk);
        pc_i  = 64'd10;
        req_i = 1'b1;
        @(posedge clk);
        #1 req_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("wait_addr", 80'(mem_addr_o), (c <= 4) ? 80'd8 : 80'd16);
            chk("wait_valid", 80'(instr_valid_o), 80'd0);
            if (c == 3) begin
                pc_i  = 64'd0;
                req_i = 1'b1;
            end else begin
                req_i = 1'b0;
            end
        end
        @(negedge clk);
        chk("wait_valid9", 80'(instr_valid_o), 80'd1);
        chk("wait_instr", instr_o, 80'h131211100F0E0D0C0B0A);
        repeat (3) @(negedge clk);
        chk("ignored_req_busy", 80'(busy_o), 80'd0);
        chk("ignored_req_reads", 80'(addr_q.size()), 80'd2);
        ack_delay = 0;

        // Asynchronous reset while in RD1.
        @(negedge clk);
        pc_i  = 64'd4;
        req_i = 1'b1;
        @(posedge clk);
        #1 req_i = 1'b0;
        @(posedge clk);
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst_mid_req", 80'(mem_req_o), 80'd0);
        chk("rst_mid_busy", 80'(busy_o), 80'd0);
        chk("rst_mid_valid", 80'(instr_valid_o), 80'd0);
        @(negedge clk);
        force_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;
        @(posedge clk);
        #1 force_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_busy", 80'(busy_o), 80'd0);
        chk("late_ack_valid", 80'(instr_valid_o), 80'd0);

        fetch("pc20", 64'd20, 3, 80'h1D1C1B1A191817161514, 1'b0);
        chk_addrs("pc20", 2, 64'd16, 64'd24, 64'd0);

        fetch("pc0b", 64'd0, 3, 80'h09080706050403020100, 1'b0);
`ifdef IMEM_WORD_REUSE_EN
        fetch("reuse10", 64'd10, 2, 80'h131211100F0E0D0C0B0A, 1'b0);
        chk_addrs("reuse10", 1, 64'd16, 64'd0, 64'd0);
`else
        fetch("noreuse10", 64'd10, 3, 80'h131211100F0E0D0C0B0A, 1'b0);
        chk_addrs("noreuse10", 2, 64'd8, 64'd16, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/imem_fetch_buffer.md
Name: imem_fetch_buffer

Overview:
- Sequential instruction-byte gatherer sitting directly upstream of the fetch stage.
- Takes a PC, reads the 64-bit little-endian instruction memory through a request/acknowledge handshake and assembles the 10 bytes a Y86 instruction can occupy.
- Hands fetch an 80-bit window plus a one-cycle valid strobe.
- Flags out-of-range PCs as an instruction-memory error without touching memory.

Parameters:
- IMEM_BYTES, 1024: instruction memory size in bytes; must be a multiple of 8 and at least 16.

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_n_i  input  1  asynchronous active-low reset
- pc_i  input  64  byte address of instruction to fetch
- req_i  input  1  fetch request, sampled only in IDLE
- busy_o  output  1  high in every state except IDLE
- instr_o  output  80  assembled bytes; [7:0]=mem[pc], [15:8]=mem[pc+1] … [79:72]=mem[pc+9]
- instr_valid_o  output  1  one-cycle strobe, instr_o/mem_error_o valid
- mem_error_o  output  1  PC out of range; qualified by instr_valid_o
- mem_req_o  output  1  memory read request
- mem_addr_o  output  64  8-byte-aligned word address, stable while mem_req_o high
- mem_ack_i  input  1  read completes this cycle; data on mem_rdata_i
- mem_rdata_i  input  64  word, byte k at bits [8k+7:8k]

Behaviour:
- Reset (async, rst_n_i low):
  - State goes to IDLE.
  - busy_o, instr_valid_o, mem_error_o, mem_req_o = 0.
  - mem_addr_o = 0, instr_o = 0.
  - Internal word registers are cleared.
  - Reset mid-fetch drops mem_req_o immediately and discards partial data.
  - A mem_ack_i arriving after reset is ignored.
- States: IDLE, RD0, RD1, RD2, DONE, ERR.
- IDLE:
  - On req_i=1, latch pc_i.
  - If pc_i > IMEM_BYTES-10, go to ERR. Compare on the full 64 bits; no wrap-around, so pc near 2^64 is an error.
  - Otherwise compute nwords = 3 if pc[2:0]==7, else 2, and go to RD0.
  - req_i while busy_o=1 is ignored; there is no queueing.
- RDk (k=0..2):
  - mem_req_o=1, mem_addr_o = {pc[63:3],3'b000} + 8k.
  - Hold both stable until mem_ack_i=1, then store mem_rdata_i in word register k.
  - Advance to RD(k+1), or to DONE when k == nwords-1.
  - mem_ack_i while mem_req_o=0 is ignored.
- DONE:
  - instr_valid_o=1 for exactly one cycle.
  - instr_o = the concatenation {w2,w1,w0} shifted right by 8*pc[2:0], low 80 bits.
  - mem_error_o=0. Return to IDLE.
- ERR:
  - instr_valid_o=1 and mem_error_o=1 for one cycle; instr_o=0. Return to IDLE.
  - No memory request is issued.
- instr_o holds its value after the strobe until the next DONE/ERR.
- Latency with zero-wait memory (ack in the same cycle as request), request accepted at edge 0:
  - 2 words: valid during cycle 3.
  - 3 words: valid during cycle 4.
  - Error: valid during cycle 1.
  - Each memory wait cycle adds one.
- Boundaries:
  - pc=IMEM_BYTES-10 is legal.
  - pc=IMEM_BYTES-9 is an error.
  - Aligned pc (pc[2:0]=0) reads 2 words.

Optional Feature:
- Macro: IMEM_WORD_REUSE_EN.
- When defined:
  - Keep the last word read (the highest-address word of the previous fetch), its address tag and a tag-valid bit; all cleared by reset.
  - If the first word address of a new fetch equals the tag and tag-valid=1, skip RD0: load word 0 from the saved register and enter RD1 directly.
  - The tag and word update on every completed memory read of the fetch's final word.
  - ERR leaves them unchanged.
- When undefined: always start at RD0; no reuse registers are present.

Test Plan:
- Memory byte n = n[7:0] everywhere; zero-wait ack. req pc=0 → reads addr 0, then 8; instr_valid_o in cycle 3; instr_o=80'h09080706050403020100; mem_error_o=0.
- req pc=7 → reads addr 0, 8, 16; valid in cycle 4; instr_o=80'h100F0E0D0C0B0A090807.
- req pc=1014 → reads 1008, 1016; instr_o bytes F6..FF; mem_error_o=0. req pc=1015 → no mem_req_o; valid in cycle 1 with mem_error_o=1, instr_o=0.
- Waits:
  - Ack delayed 3 cycles per word on pc=10: mem_addr_o stays 8, then 16, while waiting; valid in cycle 9; instr_o bytes 0A..13.
  - A req_i pulsed during busy is ignored.
- Reset mid-fetch:
  - Drop rst_n_i while in RD1 on pc=4: mem_req_o, busy_o and instr_valid_o go 0 asynchronously.
  - After release, req pc=20 completes normally with bytes 14..1D.
- With IMEM_WORD_REUSE_EN: fetch pc=0, then pc=10 → second fetch issues only addr 16 (word 8 reused); valid in cycle 2 after acceptance; instr_o bytes 0A..13. Without the macro, the same sequence issues 8 and 16.
